// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: ROB entry payload,
// ROB index type and the derived pointer/counter widths.
package reorder_buffer_pkg;

    localparam int NUM_ROB_ENTS = 64;
    localparam int DISP_WIDTH   = 2;
    localparam int RETIRE_WIDTH = 4;
    localparam int NUM_FUS      = 4;

    localparam int ROB_PTR_W  = $clog2(NUM_ROB_ENTS);
    localparam int CNT_W      = ROB_PTR_W + 1;
    localparam int RET_CNT_W  = $clog2(RETIRE_WIDTH + 1);
    localparam int RET_SLOT_W = $clog2(RETIRE_WIDTH);

    localparam int AREG_W = 5;
    localparam int PREG_W = 7;

    typedef logic [ROB_PTR_W-1:0] rob_idx_t;

    typedef struct packed {
        logic [AREG_W-1:0] dst_areg;
        logic [PREG_W-1:0] dst_preg;
        logic              exception;
        logic              br_mispred;
        logic [31:0]       pc;
    } ROB_Entry;

endpackage

// File: rtl/reorder_buffer_retire_select.sv
// Picks the retiring prefix of the head window: contiguous valid+done entries,
// stopping after (and including) the first one that needs a flush.
module rob_retire_select
    import reorder_buffer_pkg::*;
(
    input  logic [RETIRE_WIDTH-1:0] win_valid_i,
    input  logic [RETIRE_WIDTH-1:0] win_done_i,
    input  logic [RETIRE_WIDTH-1:0] win_exception_i,
    input  logic [RETIRE_WIDTH-1:0] win_br_mispred_i,
    output logic [RETIRE_WIDTH-1:0] ret_valid_o,
    output logic [RET_CNT_W-1:0]    ret_cnt_o,
    output logic                    flush_o,
    output logic [RET_SLOT_W-1:0]   flush_slot_o
);

    logic stop;

    always_comb begin
        ret_valid_o  = '0;
        ret_cnt_o    = '0;
        flush_o      = 1'b0;
        flush_slot_o = '0;
        stop         = 1'b0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (!stop && win_valid_i[k] && win_done_i[k]) begin
                ret_valid_o[k] = 1'b1;
                ret_cnt_o      = RET_CNT_W'(k + 1);
                if (win_exception_i[k] || win_br_mispred_i[k]) begin
                    flush_o      = 1'b1;
                    flush_slot_o = RET_SLOT_W'(k);
                    stop         = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at dispatch, marks done on completion,
// retires up to RETIRE_WIDTH oldest done entries and flushes on exception/mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DISP_WIDTH-1:0]               disp_valid,
    input  ROB_Entry [DISP_WIDTH-1:0]           disp_entry,
    output logic                                disp_ready,
    output rob_idx_t [DISP_WIDTH-1:0]           disp_rob_idx,
    input  logic [NUM_FUS-1:0]                  cmpl_valid,
    input  rob_idx_t [NUM_FUS-1:0]              cmpl_rob_idx,
    input  logic [NUM_FUS-1:0]                  cmpl_exception,
    input  logic [NUM_FUS-1:0]                  cmpl_br_mispred,
    output logic [RETIRE_WIDTH-1:0]             ret_valid,
    output ROB_Entry [RETIRE_WIDTH-1:0]         ret_entry,
    output logic                                flush,
    output logic [31:0]                         flush_pc,
    output logic                                rob_empty,
    output logic                                rob_full
);

    rob_idx_t              head_q, head_d;
    rob_idx_t              tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [NUM_ROB_ENTS-1:0] valid_q;
    logic [NUM_ROB_ENTS-1:0] done_q;
    ROB_Entry              entry_q [NUM_ROB_ENTS];

    rob_idx_t [RETIRE_WIDTH-1:0] win_idx;
    logic [RETIRE_WIDTH-1:0]     win_valid, win_done, win_exception, win_br_mispred;
    logic [RET_CNT_W-1:0]        ret_cnt;
    logic [RET_SLOT_W-1:0]       flush_slot;
    logic                        disp_fire;
    logic [CNT_W-1:0]            disp_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_win
            assign win_idx[gi]        = head_q + rob_idx_t'(gi);
            assign win_valid[gi]      = valid_q[win_idx[gi]];
            assign win_done[gi]       = done_q[win_idx[gi]];
            assign win_exception[gi]  = entry_q[win_idx[gi]].exception;
            assign win_br_mispred[gi] = entry_q[win_idx[gi]].br_mispred;
            assign ret_entry[gi]      = entry_q[win_idx[gi]];
        end
        for (gi = 0; gi < DISP_WIDTH; gi++) begin : g_disp_idx
            assign disp_rob_idx[gi] = tail_q + rob_idx_t'(gi);
        end
    endgenerate

    rob_retire_select u_retire_select (
        .win_valid_i      (win_valid),
        .win_done_i       (win_done),
        .win_exception_i  (win_exception),
        .win_br_mispred_i (win_br_mispred),
        .ret_valid_o      (ret_valid),
        .ret_cnt_o        (ret_cnt),
        .flush_o          (flush),
        .flush_slot_o     (flush_slot)
    );

    // Space check uses registered count only; same-cycle retires do not free slots.
    assign disp_ready = (count_q <= CNT_W'(NUM_ROB_ENTS - DISP_WIDTH));
    assign disp_fire  = disp_ready && !flush;
    assign rob_empty  = (count_q == '0);
    assign rob_full   = (count_q == CNT_W'(NUM_ROB_ENTS));
    assign flush_pc   = flush ? ret_entry[flush_slot].pc : 32'h0;

    always_comb begin
        disp_cnt = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            if (disp_valid[i]) begin
                disp_cnt = disp_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        head_d = head_q + rob_idx_t'(ret_cnt);
        if (flush) begin
            tail_d  = head_d;
            count_d = '0;
        end else if (disp_fire) begin
            tail_d  = tail_q + rob_idx_t'(disp_cnt);
            count_d = count_q + disp_cnt - CNT_W'(ret_cnt);
        end else begin
            tail_d  = tail_q;
            count_d = count_q - CNT_W'(ret_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            for (int e = 0; e < NUM_ROB_ENTS; e++) begin
                entry_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush) begin
                valid_q <= '0;
                done_q  <= '0;
            end else begin
                // Completions to already-freed entries are stale and dropped.
                for (int f = 0; f < NUM_FUS; f++) begin
                    if (cmpl_valid[f] && valid_q[cmpl_rob_idx[f]]) begin
                        done_q[cmpl_rob_idx[f]]             <= 1'b1;
                        entry_q[cmpl_rob_idx[f]].exception  <= entry_q[cmpl_rob_idx[f]].exception | cmpl_exception[f];
                        entry_q[cmpl_rob_idx[f]].br_mispred <= entry_q[cmpl_rob_idx[f]].br_mispred | cmpl_br_mispred[f];
                    end
                end
                for (int k = 0; k < RETIRE_WIDTH; k++) begin
                    if (ret_valid[k]) begin
                        valid_q[win_idx[k]] <= 1'b0;
                        done_q[win_idx[k]]  <= 1'b0;
                    end
                end
                if (disp_fire) begin
                    for (int i = 0; i < DISP_WIDTH; i++) begin
                        if (disp_valid[i]) begin
                            valid_q[disp_rob_idx[i]] <= 1'b1;
                            done_q[disp_rob_idx[i]]  <= 1'b0;
                            entry_q[disp_rob_idx[i]] <= disp_entry[i];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, fill to full, out-of-order completion,
// mispredict flush, stale completion and pointer wrap.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [DISP_WIDTH-1:0]       disp_valid = '0;
    ROB_Entry [DISP_WIDTH-1:0]   disp_entry = '0;
    logic                        disp_ready;
    rob_idx_t [DISP_WIDTH-1:0]   disp_rob_idx;
    logic [NUM_FUS-1:0]          cmpl_valid = '0;
    rob_idx_t [NUM_FUS-1:0]      cmpl_rob_idx = '0;
    logic [NUM_FUS-1:0]          cmpl_exception = '0;
    logic [NUM_FUS-1:0]          cmpl_br_mispred = '0;
    logic [RETIRE_WIDTH-1:0]     ret_valid;
    ROB_Entry [RETIRE_WIDTH-1:0] ret_entry;
    logic                        flush;
    logic [31:0]                 flush_pc;
    logic                        rob_empty;
    logic                        rob_full;

    int checks   = 0;
    int failures = 0;

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .disp_valid      (disp_valid),
        .disp_entry      (disp_entry),
        .disp_ready      (disp_ready),
        .disp_rob_idx    (disp_rob_idx),
        .cmpl_valid      (cmpl_valid),
        .cmpl_rob_idx    (cmpl_rob_idx),
        .cmpl_exception  (cmpl_exception),
        .cmpl_br_mispred (cmpl_br_mispred),
        .ret_valid       (ret_valid),
        .ret_entry       (ret_entry),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .rob_empty       (rob_empty),
        .rob_full        (rob_full)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic ROB_Entry mk(input logic [31:0] pc);
        ROB_Entry e;
        e.dst_areg   = pc[6:2];
        e.dst_preg   = pc[8:2];
        e.exception  = 1'b0;
        e.br_mispred = 1'b0;
        e.pc         = pc;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid      = '0;
        cmpl_valid      = '0;
        cmpl_exception  = '0;
        cmpl_br_mispred = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        $display("reset released");
    endtask

    task automatic dispatch2(input logic [31:0] pc_a, input logic [31:0] pc_b);
        disp_valid    = 2'b11;
        disp_entry[0] = mk(pc_a);
        disp_entry[1] = mk(pc_b);
        $display("dispatch idx=%0d,%0d pc=%h,%h", disp_rob_idx[0], disp_rob_idx[1], pc_a, pc_b);
        tick();
        disp_valid = '0;
    endtask

    task automatic set_cmpl(input int port, input int idx, input logic exc, input logic mis);
        cmpl_valid[port]      = 1'b1;
        cmpl_rob_idx[port]    = rob_idx_t'(idx);
        cmpl_exception[port]  = exc;
        cmpl_br_mispred[port] = mis;
        $display("complete port=%0d idx=%0d exc=%0b mis=%0b", port, idx, exc, mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ord [4];
        int n;
        ROB_Entry exp_e;
        ord = '{3, 1, 2, 0};

        // Reset then idle
        do_reset();
        check_value("rst_empty",  64'(rob_empty), 1);
        check_value("rst_ready",  64'(disp_ready), 1);
        check_value("rst_full",   64'(rob_full), 0);
        check_value("rst_ret",    64'(ret_valid), 0);
        check_value("rst_flush",  64'(flush), 0);
        check_value("rst_fpc",    64'(flush_pc), 0);
        check_value("rst_idx0",   64'(disp_rob_idx[0]), 0);
        check_value("rst_idx1",   64'(disp_rob_idx[1]), 1);

        // Fill: 32 cycles of 2
        for (int c = 0; c < 32; c++) begin
            check_value("fill_ready", 64'(disp_ready), 1);
            check_value("fill_idx",   64'(disp_rob_idx[0]), 64'(2 * c));
            dispatch2(32'h1000 + 32'(8 * c), 32'h1004 + 32'(8 * c));
        end
        check_value("full_full",  64'(rob_full), 1);
        check_value("full_ready", 64'(disp_ready), 0);
        check_value("full_empty", 64'(rob_empty), 0);
        dispatch2(32'hdead0000, 32'hdead0004);
        check_value("full_hold",     64'(rob_full), 1);
        check_value("full_tail",     64'(disp_rob_idx[0]), 0);
        check_value("full_noretire", 64'(ret_valid), 0);

        // Out-of-order completion 3,1,2,0
        for (int j = 0; j < 4; j++) begin
            set_cmpl(0, ord[j], 1'b0, 1'b0);
            tick();
            idle_inputs();
            if (j < 3) begin
                check_value("ooo_wait", 64'(ret_valid), 0);
            end
        end
        check_value("ooo_ret",   64'(ret_valid), 64'hf);
        check_value("ooo_pc0",   64'(ret_entry[0].pc), 64'h1000);
        check_value("ooo_pc3",   64'(ret_entry[3].pc), 64'h100c);
        check_value("ooo_flush", 64'(flush), 0);
        tick();
        check_value("ooo_after_ret",   64'(ret_valid), 0);
        check_value("ooo_after_full",  64'(rob_full), 0);
        check_value("ooo_after_ready", 64'(disp_ready), 1);
        set_cmpl(0, 4, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check_value("ooo_head4_ret", 64'(ret_valid), 64'h1);
        check_value("ooo_head4_pc",  64'(ret_entry[0].pc), 64'h1010);
        tick();

        // Mid-operation reset, then mispredict flush
        do_reset();
        check_value("rst2_empty", 64'(rob_empty), 1);
        check_value("rst2_idx0",  64'(disp_rob_idx[0]), 0);
        check_value("rst2_ret",   64'(ret_valid), 0);
        for (int c = 0; c < 3; c++) begin
            dispatch2(32'h2000 + 32'(8 * c), 32'h2004 + 32'(8 * c));
        end
        set_cmpl(0, 0, 1'b0, 1'b0);
        set_cmpl(1, 1, 1'b0, 1'b1);
        set_cmpl(2, 2, 1'b0, 1'b0);
        set_cmpl(3, 3, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check_value("fl_ret",   64'(ret_valid), 64'h3);
        check_value("fl_flush", 64'(flush), 1);
        check_value("fl_pc",    64'(flush_pc), 64'h2004);
        // Dispatch during the flush cycle must be dropped
        dispatch2(32'h9990, 32'h9994);
        check_value("fl_empty", 64'(rob_empty), 1);
        check_value("fl_tail",  64'(disp_rob_idx[0]), 2);
        check_value("fl_ret0",  64'(ret_valid), 0);
        check_value("fl_clear", 64'(flush), 0);

        // Stale completion to a flushed entry
        set_cmpl(0, 5, 1'b1, 1'b0);
        tick();
        idle_inputs();
        check_value("stale_ret",   64'(ret_valid), 0);
        check_value("stale_empty", 64'(rob_empty), 1);
        check_value("stale_flush", 64'(flush), 0);

        // Head now at 2
        check_value("h2_idx0", 64'(disp_rob_idx[0]), 2);
        check_value("h2_idx1", 64'(disp_rob_idx[1]), 3);
        dispatch2(32'h3000, 32'h3004);
        set_cmpl(0, 2, 1'b0, 1'b0);
        set_cmpl(1, 3, 1'b0, 1'b0);
        tick();
        idle_inputs();
        exp_e = mk(32'h3004);
        check_value("h2_ret",   64'(ret_valid), 64'h3);
        check_value("h2_pc0",   64'(ret_entry[0].pc), 64'h3000);
        check_value("h2_preg1", 64'(ret_entry[1].dst_preg), 64'(exp_e.dst_preg));
        check_value("h2_flush", 64'(flush), 0);
        tick();
        check_value("h2_empty", 64'(rob_empty), 1);

        // Pointer wrap: bring head to 62
        do_reset();
        for (int c = 0; c < 31; c++) begin
            dispatch2(32'h4000 + 32'(8 * c), 32'h4004 + 32'(8 * c));
        end
        for (int b = 0; b < 16; b++) begin
            for (int p = 0; p < 4; p++) begin
                if (4 * b + p < 62) set_cmpl(p, 4 * b + p, 1'b0, 1'b0);
            end
            tick();
            idle_inputs();
        end
        n = 0;
        while (!rob_empty && n < 20) begin
            tick();
            n++;
        end
        check_value("wrap_drain", 64'(rob_empty), 1);
        check_value("wrap_idx0",  64'(disp_rob_idx[0]), 62);
        check_value("wrap_idx1",  64'(disp_rob_idx[1]), 63);
        dispatch2(32'h5000, 32'h5004);
        check_value("wrap_idx2", 64'(disp_rob_idx[0]), 0);
        check_value("wrap_idx3", 64'(disp_rob_idx[1]), 1);
        dispatch2(32'h5008, 32'h500c);
        set_cmpl(0, 62, 1'b0, 1'b0);
        set_cmpl(1, 63, 1'b0, 1'b0);
        set_cmpl(2, 0, 1'b0, 1'b0);
        set_cmpl(3, 1, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check_value("wrap_ret", 64'(ret_valid), 64'hf);
        check_value("wrap_pc0", 64'(ret_entry[0].pc), 64'h5000);
        check_value("wrap_pc2", 64'(ret_entry[2].pc), 64'h5008);
        check_value("wrap_pc3", 64'(ret_entry[3].pc), 64'h500c);
        tick();
        check_value("wrap_empty", 64'(rob_empty), 1);
        check_value("wrap_head2", 64'(disp_rob_idx[0]), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
